aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption round sequencer for the SIMD processor. It holds the 128-bit state as vecSize columns of regSize bits and steps it through SubBytes, ShiftRows, MixColumns and AddRoundKey, one stage per clock. It fetches round keys from an external key store by index. It has valid/ready handshakes on both the input block and the output block.

Parameters:
regSize, 32, width of one state column (4 bytes; row 0 in bits [31:24]).
vecSize, 4, number of columns in the state.
NUM_ROUNDS, 10, number of AES rounds (Nr); 12 or 14 are also legal if the key store supplies those keys.

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  block_in is valid.
in_ready  out  1  block accepted on the clk edge where in_valid && in_ready.
block_in  in  [vecSize-1:0][regSize-1:0]  plaintext; element i is column i.
out_valid  out  1  block_out holds the finished ciphertext.
out_ready  in  1  consumer accepts block_out.
block_out  out  [vecSize-1:0][regSize-1:0]  ciphertext, same layout as block_in.
key_idx  out  $clog2(NUM_ROUNDS+1)  index of the round key being requested.
round_key  in  [vecSize-1:0][regSize-1:0]  round key key_idx, supplied combinationally in the same cycle.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state goes to IDLE, round counter 0, state register 0. Outputs: in_ready=1, out_valid=0, busy=0, key_idx=0, block_out=0.
- Stage logic: instances of sub_bytes, shift_rows and mix_columns (each #(regSize,vecSize), vect_in/vect_out) all read the state register. AddRoundKey is a local XOR. The FSM selects which result is written back.
- FSM states: IDLE, SUB, SHIFT, MIX, ADDK, DONE.
- IDLE: in_ready=1, key_idx=0. On in_valid, register state <= block_in ^ round_key, round <= 1, go to SUB.
- SUB -> SHIFT, writing sub_bytes result.
- SHIFT writes shift_rows result, then goes to MIX if round < NUM_ROUNDS, otherwise to ADDK (the final round skips MixColumns).
- MIX -> ADDK, writing mix_columns result.
- ADDK: key_idx=round; state <= state ^ round_key. If round == NUM_ROUNDS go to DONE, else round++ and go to SUB.
- key_idx equals round only in ADDK, and 0 in every other state.
- DONE: out_valid=1 and block_out=state register. Both stay stable until out_ready. On out_ready go to IDLE; out_valid falls on that edge.
- block_out is registered and holds the last ciphertext after the handshake; it is not cleared.
- Latency (NUM_ROUNDS=10): out_valid rises 39 edges after the accept edge (4×9 + 3). Back-to-back throughput is one block per 41 cycles: accept in IDLE, 39 processing edges, one handshake edge.
- in_ready=0 whenever the FSM is not in IDLE; in_valid is ignored there.
- out_ready while not in DONE has no effect.
- Reset asserted mid-block aborts immediately; the partial state is discarded and no out_valid is produced.
- Round counter width is $clog2(NUM_ROUNDS+1); it never wraps because its range is 1..NUM_ROUNDS.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_state_t ([vecSize-1:0][regSize-1:0]);
  - enum aes_ctrl_state_e {IDLE, SUB, SHIFT, MIX, ADDK, DONE};
  - localparams AES128_ROUNDS=10, AES192_ROUNDS=12, AES256_ROUNDS=14.
- One natural sub-module: add_round_key (combinational column-wise XOR), reused later by the decrypt controller.
- The FSM and state register stay in aes_round_ctrl.

Test Plan:
- Key store model: returns expanded keys combinationally from key_idx.
- FIPS-197 C.1: block_in={00112233,44556677,8899aabb,ccddeeff}, key 000102..0f.
  - Required: out_valid exactly 39 edges after accept, block_out={69c4e0d8,6a7b0430,d8cdb780,70b4c55a}.
  - The state register after the round-1 ADDK equals {89d810e8,855ace68,2d1843d8,cb128fe4}.
- All-zero key and plaintext -> block_out={66e94bd4,ef8a2c3b,884cfa59,ca342b2e}.
- key_idx trace over one block: 0 at accept, then 1..10 in the ADDK cycles, 0 elsewhere; exactly 11 key reads.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - Required: out_valid=1, block_out stable, in_ready=0 throughout.
  - Raise out_ready: in_ready=1 the next cycle. A second block with in_valid held high is accepted 41 cycles after the first.
- Reset 20 cycles into a block:
  - Outputs return to reset values without waiting for a clock edge.
  - A new block is then processed correctly (repeat C.1), with no stray out_valid.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, round counts and GF(2^8) helpers
package aes_pkg;

  localparam int REG_SIZE      = 32;
  localparam int VEC_SIZE      = 4;
  localparam int AES128_ROUNDS = 10;
  localparam int AES192_ROUNDS = 12;
  localparam int AES256_ROUNDS = 14;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] aes_state_t;

  typedef enum logic [2:0] {IDLE, SUB, SHIFT, MIX, ADDK, DONE} aes_ctrl_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = b;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/add_round_key.sv
// rtl/add_round_key.sv - column-wise XOR of the state with a round key
module add_round_key #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] vect_in,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  output logic [vecSize-1:0][regSize-1:0] vect_out
);

  for (genvar c = 0; c < vecSize; c++) begin : g_col
    assign vect_out[c] = vect_in[c] ^ key_in[c];
  end

endmodule

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - MixColumns matrix {2,3,1,1} applied to each column
module mix_columns
  import aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] vect_in,
  output logic [vecSize-1:0][regSize-1:0] vect_out
);

  function automatic logic [7:0] row_byte(input logic [regSize-1:0] col, input int r);
    return col[regSize-8-8*(r % 4) +: 8];
  endfunction

  // out_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), rows taken mod 4.
  always_comb begin
    vect_out = '0;
    for (int c = 0; c < vecSize; c++) begin
      for (int r = 0; r < 4; r++) begin
        vect_out[c][regSize-8-8*r +: 8] =
          xtime(row_byte(vect_in[c], r)) ^
          xtime(row_byte(vect_in[c], r + 1)) ^ row_byte(vect_in[c], r + 1) ^
          row_byte(vect_in[c], r + 2) ^ row_byte(vect_in[c], r + 3);
      end
    end
  end

endmodule

// File: rtl/shift_rows.sv
// rtl/shift_rows.sv - rotate row r left by r columns (row 0 is the top byte)
module shift_rows #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] vect_in,
  output logic [vecSize-1:0][regSize-1:0] vect_out
);

  // Output column c, row r comes from input column (c + r) mod vecSize, same row.
  always_comb begin
    vect_out = '0;
    for (int c = 0; c < vecSize; c++) begin
      for (int r = 0; r < regSize / 8; r++) begin
        vect_out[c][regSize-8-8*r +: 8] = vect_in[(c + r) % vecSize][regSize-8-8*r +: 8];
      end
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - byte-wise S-box substitution over every state column
module sub_bytes
  import aes_pkg::*;
#(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic [vecSize-1:0][regSize-1:0] vect_in,
  output logic [vecSize-1:0][regSize-1:0] vect_out
);

  // Every byte goes through its own S-box; no cross-byte dependency.
  always_comb begin
    vect_out = '0;
    for (int c = 0; c < vecSize; c++) begin
      for (int b = 0; b < regSize / 8; b++) begin
        vect_out[c][b*8 +: 8] = sbox(vect_in[c][b*8 +: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES encrypt sequencer, one stage per clock
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int regSize    = 32,
  parameter int vecSize    = 4,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [vecSize-1:0][regSize-1:0]       block_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [vecSize-1:0][regSize-1:0]       block_out,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]       key_idx,
  input  logic [vecSize-1:0][regSize-1:0]       round_key,
  output logic                                  busy
);

  localparam int KW = $clog2(NUM_ROUNDS + 1);
  localparam logic [KW-1:0] LAST_ROUND = KW'(NUM_ROUNDS);
  localparam logic [KW-1:0] ROUND_ONE  = KW'(1);

  aes_ctrl_state_e state_q, state_d;
  logic [KW-1:0] round_q, round_d;
  logic [vecSize-1:0][regSize-1:0] data_q, data_d;
  logic [vecSize-1:0][regSize-1:0] out_q, out_d;

  logic [vecSize-1:0][regSize-1:0] sb_res, sr_res, mc_res, ark_in, ark_res;

  sub_bytes #(.regSize(regSize), .vecSize(vecSize)) u_sub_bytes (
    .vect_in (data_q),
    .vect_out(sb_res)
  );

  shift_rows #(.regSize(regSize), .vecSize(vecSize)) u_shift_rows (
    .vect_in (data_q),
    .vect_out(sr_res)
  );

  mix_columns #(.regSize(regSize), .vecSize(vecSize)) u_mix_columns (
    .vect_in (data_q),
    .vect_out(mc_res)
  );

  // The initial whitening in IDLE and every ADDK share one XOR; only its input differs.
  assign ark_in = (state_q == IDLE) ? block_in : data_q;

  add_round_key #(.regSize(regSize), .vecSize(vecSize)) u_add_round_key (
    .vect_in (ark_in),
    .key_in  (round_key),
    .vect_out(ark_res)
  );

  // Next-state, stage write-back selection and handshake/key outputs.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    data_d   = data_q;
    out_d    = out_q;
    in_ready = 1'b0;
    key_idx  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = ark_res;
          round_d = ROUND_ONE;
          state_d = SUB;
        end
      end
      SUB: begin
        data_d  = sb_res;
        state_d = SHIFT;
      end
      SHIFT: begin
        data_d  = sr_res;
        state_d = (round_q < LAST_ROUND) ? MIX : ADDK;
      end
      MIX: begin
        data_d  = mc_res;
        state_d = ADDK;
      end
      ADDK: begin
        key_idx = round_q;
        data_d  = ark_res;
        if (round_q == LAST_ROUND) begin
          out_d   = ark_res;
          state_d = DONE;
        end else begin
          round_d = round_q + ROUND_ONE;
          state_d = SUB;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round counter, working state and the held ciphertext.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign block_out = out_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - scoreboard bench for aes_round_ctrl with FIPS-197 vectors
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  aes_state_t block_in, block_out, round_key;
  logic [3:0] key_idx;

  always #5 clk = ~clk;

  aes_round_ctrl #(.regSize(32), .vecSize(4), .NUM_ROUNDS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .block_in (block_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .block_out(block_out),
    .key_idx  (key_idx),
    .round_key(round_key),
    .busy     (busy)
  );

  // Key store: expanded keys indexed combinationally by key_idx.
  aes_state_t rk [0:10];
  assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    aes_state_t data;
    int         acc;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box by brute-force inverse search.
  function automatic logic [7:0] t_sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (t_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {t_sbox(t[31:24]), t_sbox(t[23:16]), t_sbox(t[15:8]), t_sbox(t[7:0])};
        t = t ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < 4; c++) rk[r][c] = w[4*r + c];
  endtask

  function automatic aes_state_t mk(input logic [31:0] c0, input logic [31:0] c1,
                                    input logic [31:0] c2, input logic [31:0] c3);
    aes_state_t s;
    s[0] = c0;
    s[1] = c1;
    s[2] = c2;
    s[3] = c3;
    return s;
  endfunction

  // Monitor: latency on each out_valid rise, data on each handshake.
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_v) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL stray_out_valid: got out_valid=1 expected no pending block");
        end else begin
          chk("latency", 128'(cyc - sb_q[0].acc), 128'd39);
        end
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        chk("ciphertext", block_out, sb_q[0].data);
        void'(sb_q.pop_front());
      end
    end
    prev_v = rst ? 1'b0 : out_valid;
  end

  // Called at a negedge; returns at the negedge after the accept edge, in_valid left high.
  task automatic send(input aes_state_t blk, input aes_state_t exp, output int acc);
    int n;
    n        = 0;
    acc      = -1;
    in_valid = 1'b1;
    block_in = blk;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      acc = cyc + 1;
      sb_q.push_back('{exp, acc});
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_key_idx"}, 128'(key_idx), 128'd0);
    chk({tag, "_block_out"}, block_out, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    aes_state_t pt_c1, ct_c1, r1_c1, ct_zero, held;
    logic [127:0] key_c1;
    int a1, a2, nk, n;
    logic saw1;

    pt_c1   = mk(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
    ct_c1   = mk(32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a);
    r1_c1   = mk(32'h89d810e8, 32'h855ace68, 32'h2d1843d8, 32'hcb128fe4);
    ct_zero = mk(32'h66e94bd4, 32'hef8a2c3b, 32'h884cfa59, 32'hca342b2e);
    key_c1  = 128'h000102030405060708090a0b0c0d0e0f;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    block_in  = '0;
    expand(key_c1);
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // C.1 with key-index trace and round-1 intermediate.
    chk("key_idx_idle", 128'(key_idx), 128'd0);
    send(pt_c1, ct_c1, a1);
    in_valid = 1'b0;
    nk   = 0;
    saw1 = 1'b0;
    n    = 0;
    while (!out_valid && n < 60) begin
      if (saw1) begin
        chk("state_after_round1", dut.data_q, r1_c1);
        saw1 = 1'b0;
      end
      if (key_idx != 4'd0) begin
        nk++;
        chk("key_idx_seq", 128'(key_idx), 128'(nk));
        if (key_idx == 4'd1) saw1 = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("key_reads", 128'(nk + 1), 128'd11);
    drain("c1");

    // All-zero key and plaintext.
    expand(128'h0);
    @(negedge clk);
    send('0, ct_zero, a1);
    in_valid = 1'b0;
    drain("zero");

    // Backpressure in DONE for 5 cycles.
    expand(key_c1);
    @(negedge clk);
    out_ready = 1'b0;
    send(pt_c1, ct_c1, a1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    held = block_out;
    chk("bp_block_out", held, ct_c1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_stable", block_out, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 128'(in_ready), 128'd1);
    chk("bp_block_out_held", block_out, ct_c1);
    drain("bp");

    // Back-to-back with in_valid held high.
    send(pt_c1, ct_c1, a1);
    send(pt_c1, ct_c1, a2);
    in_valid = 1'b0;
    chk("b2b_interval", 128'(a2 - a1), 128'd41);
    drain("b2b");

    // Reset 20 cycles into a block, then a clean C.1.
    send(pt_c1, ct_c1, a1);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(pt_c1, ct_c1, a1);
    in_valid = 1'b0;
    drain("after_reset");
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
